// File: rtl/tgate_arb_pkg.sv
// Shared types and helpers for the transmission-gate bus arbiter.
package tgate_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      TURN = 2'd2
   } arb_state_t;

   function automatic int owner_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/tgate_rr_pick.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module tgate_rr_pick
   import tgate_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PW    = owner_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    rr_ptr,
   output logic             found,
   output logic [PW-1:0]    pick
);

   logic [N_REQ-1:0] rot_s;
   logic [PW-1:0]    enc_s;
   logic [PW:0]      sum_s;

   // rotate so rr_ptr lands at bit 0, priority-encode, then rotate the index back
   always_comb begin
      rot_s = N_REQ'({req, req} >> rr_ptr);
      enc_s = {PW{1'b0}};
      for (int i = N_REQ - 1; i >= 0; i--) begin
         enc_s = rot_s[i] ? PW'(i) : enc_s;
      end
      sum_s = {1'b0, enc_s} + {1'b0, rr_ptr};
      pick  = (sum_s >= (PW+1)'(N_REQ)) ? PW'(sum_s - (PW+1)'(N_REQ)) : sum_s[PW-1:0];
      found = |req;
   end

endmodule

// File: rtl/tgate_bus_arbiter.sv
// Round-robin owner of N_REQ pass-gate enables on one shared wire, with a hold cap
// and break-before-make dead cycles between owners.
module tgate_bus_arbiter
   import tgate_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int HOLD_MAX = 8,
   parameter int TURN_CYC = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req,
   output logic [N_REQ-1:0]            control,
   output logic [owner_w(N_REQ)-1:0]   owner,
   output logic                        busy,
   output logic                        preempt
);

   localparam int PW = owner_w(N_REQ);
   localparam int HW = $clog2(HOLD_MAX + 1);
   localparam int TW = $clog2(TURN_CYC + 1);
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

   arb_state_t       state_q,    state_d;
   logic [N_REQ-1:0] control_q,  control_d;
   logic [PW-1:0]    owner_q,    owner_d;
   logic             busy_q,     busy_d;
   logic             preempt_q,  preempt_d;
   logic [PW-1:0]    rr_ptr_q,   rr_ptr_d;
   logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
   logic [TW-1:0]    turn_cnt_q, turn_cnt_d;

   logic             pick_found_s;
   logic [PW-1:0]    pick_idx_s;
   logic             grant_s;
   logic             release_s;

   tgate_rr_pick #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .found  (pick_found_s),
      .pick   (pick_idx_s)
   );

   // next-state logic: decide grant/release, then apply the common grant or release effects
   always_comb begin
      state_d    = state_q;
      control_d  = control_q;
      owner_d    = owner_q;
      busy_d     = busy_q;
      preempt_d  = 1'b0;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      turn_cnt_d = turn_cnt_q;
      grant_s    = 1'b0;
      release_s  = 1'b0;

      case (state_q)
         IDLE: begin
            grant_s = pick_found_s;
         end
         OWN: begin
            // a req drop wins over a simultaneous hold expiry, so no preempt then
            if (!req[owner_q]) begin
               release_s = 1'b1;
            end else if (hold_cnt_q == HW'(HOLD_MAX)) begin
               release_s = 1'b1;
               preempt_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end
         TURN: begin
            if (turn_cnt_q <= TW'(1)) begin
               turn_cnt_d = {TW{1'b0}};
               if (pick_found_s) begin
                  grant_s = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               turn_cnt_d = turn_cnt_q - TW'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            control_d = {N_REQ{1'b0}};
            busy_d    = 1'b0;
         end
      endcase

      case ({grant_s, release_s})
         2'b10: begin
            state_d    = OWN;
            control_d  = ONE_HOT0 << pick_idx_s;
            owner_d    = pick_idx_s;
            busy_d     = 1'b1;
            hold_cnt_d = HW'(1);
         end
         2'b01: begin
            state_d    = TURN;
            control_d  = {N_REQ{1'b0}};
            busy_d     = 1'b0;
            rr_ptr_d   = (owner_q == PW'(N_REQ - 1)) ? {PW{1'b0}} : owner_q + PW'(1);
            turn_cnt_d = TW'(TURN_CYC);
         end
         default: begin
            hold_cnt_d = hold_cnt_d;
         end
      endcase
   end

   // state and output registers; reset drops every gate enable without waiting for clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         control_q  <= {N_REQ{1'b0}};
         owner_q    <= {PW{1'b0}};
         busy_q     <= 1'b0;
         preempt_q  <= 1'b0;
         rr_ptr_q   <= {PW{1'b0}};
         hold_cnt_q <= {HW{1'b0}};
         turn_cnt_q <= {TW{1'b0}};
      end else begin
         state_q    <= state_d;
         control_q  <= control_d;
         owner_q    <= owner_d;
         busy_q     <= busy_d;
         preempt_q  <= preempt_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
         turn_cnt_q <= turn_cnt_d;
      end
   end

   assign control = control_q;
   assign owner   = owner_q;
   assign busy    = busy_q;
   assign preempt = preempt_q;

endmodule

// File: tb/tb_tgate_bus_arbiter.sv
// Scoreboard bench for tgate_bus_arbiter driving a modelled pass-gate bank on one wire.
module tb_tgate_bus_arbiter;

   localparam int N = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req   = 4'b0000;
   logic [3:0] control;
   logic [1:0] owner;
   logic       busy;
   logic       preempt;

   tgate_bus_arbiter #(
      .N_REQ    (4),
      .HOLD_MAX (8),
      .TURN_CYC (1)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .control (control),
      .owner   (owner),
      .busy    (busy),
      .preempt (preempt)
   );

   // free-running clock, 10 ns period
   always #5 clk = ~clk;

   logic [7:0] data [N] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};
   logic [7:0] gate_y [N];
   logic [7:0] bus_y;
   logic [2:0] bus_drv;

   for (genvar g = 0; g < N; g++) begin : g_gate
      assign gate_y[g] = control[g] ? data[g] : 8'h00;
   end

   // shared wire: count conducting gates and merge what they drive
   always_comb begin
      bus_y   = 8'h00;
      bus_drv = 3'd0;
      for (int i = 0; i < N; i++) begin
         if (control[i]) begin
            bus_y   = bus_y | gate_y[i];
            bus_drv = bus_drv + 3'd1;
         end else begin
            bus_y   = bus_y;
         end
      end
   end

   int          vectors     = 0;
   int          miscompares = 0;
   string       test_tag    = "init";
   logic [18:0] exp_q [$];
   logic [3:0]  prev_ctrl   = 4'b0000;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // packed expectation: {control, busy, owner, preempt, gates conducting, wire value}
   function automatic logic [18:0] mk(input logic [3:0] c, input logic b, input logic [1:0] o,
                                      input logic p);
      return {c, b, o, p, (b ? 3'd1 : 3'd0), (b ? data[o] : 8'h00)};
   endfunction

   function automatic logic [18:0] own(input logic [1:0] o);
      return mk(4'b0001 << o, 1'b1, o, 1'b0);
   endfunction

   function automatic logic [18:0] dead(input logic p);
      return mk(4'b0000, 1'b0, 2'd0, p);
   endfunction

   // scoreboard: pop one expectation per cycle that stimulus was applied
   always @(negedge clk) begin
      logic [18:0] e;
      logic [18:0] obs;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         obs = {control, busy, (e[14] ? owner : 2'b00), preempt, bus_drv, bus_y};
         check_val(test_tag, 32'(obs), 32'(e));
      end
   end

   // invariants on every running cycle
   always @(negedge clk) begin
      if (rst_n) begin
         check_val("onehot0", 32'($onehot0(control)), 32'd1);
         check_val("busy_or", 32'(busy), 32'(|control));
         check_val("contention", 32'(bus_drv <= 3'd1), 32'd1);
         check_val("bbm", 32'((prev_ctrl != 4'b0000) && (control != 4'b0000) && (prev_ctrl != control)),
                   32'd0);
      end
      prev_ctrl = control;
   end

   task automatic step(input logic [3:0] r, input logic [18:0] e);
      req = r;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      @(negedge clk);
      #1;
      check_val("reset_state", 32'({control, busy, owner, preempt, bus_drv}), 32'd0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      test_tag = "t1_idle";
      do_reset();
      repeat (5) step(4'b0000, dead(1'b0));

      test_tag = "t2_single";
      step(4'b0100, own(2'd2));
      step(4'b0100, own(2'd2));
      step(4'b0000, dead(1'b0));
      step(4'b0000, dead(1'b0));
      step(4'b0000, dead(1'b0));

      test_tag = "t3_all";
      do_reset();
      for (int k = 0; k < 5; k++) begin
         repeat (8) step(4'b1111, own(seq[k]));
         step(4'b1111, dead(1'b1));
      end

      test_tag = "t4_lone";
      do_reset();
      repeat (2) begin
         repeat (8) step(4'b0001, own(2'd0));
         step(4'b0001, dead(1'b1));
      end

      test_tag = "t5_async";
      do_reset();
      repeat (2) step(4'b0010, own(2'd1));
      step(4'b0000, dead(1'b0));
      repeat (3) step(4'b0100, own(2'd2));
      rst_n = 1'b0;
      #1;
      check_val("t5_async_drop", 32'({control, busy, preempt, bus_drv}), 32'd0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) step(4'b1111, own(2'd0));

      test_tag = "t6_drop_at_max";
      do_reset();
      repeat (8) step(4'b0010, own(2'd1));
      step(4'b0000, dead(1'b0));
      step(4'b0000, dead(1'b0));

      check_val("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
